// File: rtl/alu_result_collector_pkg.sv
// Shared definitions for the ALU result collector: sel encodings, data width
// and the layout of a buffered entry {sel, result, c, z, n}.
package alu_result_collector_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_sel_e;

    localparam int ALU_W  = 16;
    localparam int SEL_W  = 2;
    localparam int FLAG_W = 3;   // c, z, n
    localparam int DROP_W = 8;

    function automatic int entry_w(input int w);
        return w + SEL_W + FLAG_W;
    endfunction

endpackage

// File: rtl/alu_fifo_mem.sv
// DEPTH x EW register array: one synchronous write port, one asynchronous read port.
module alu_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int EW    = 21
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [EW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [EW-1:0]            rdata
);

    logic [EW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/alu_result_collector.sv
// Captures ALU results with derived z/n flags into a first-word fall-through
// FIFO, drained by a valid/ready consumer; counts pushes refused while full.
module alu_result_collector
    import alu_result_collector_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = ALU_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic [W-1:0]             in_result,
    input  logic                     in_c,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SEL_W-1:0]         out_sel,
    output logic [W-1:0]             out_result,
    output logic                     out_c,
    output logic                     out_z,
    output logic                     out_n,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    output logic [DROP_W-1:0]        drop_cnt,
    input  logic                     clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = entry_w(W);
    localparam logic [CW-1:0]     FULL     = CW'(DEPTH);
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [EW-1:0] wr_data, rd_data, hold_q, head;
    logic          push, pop, drop;

    assign in_ready  = (count < FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign drop      = in_valid && !in_ready;

    assign wr_data = {in_sel, in_result, in_c, (in_result == '0), in_result[W-1]};

    alu_fifo_mem #(.DEPTH(DEPTH), .EW(EW)) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                hold_q <= rd_data;
            end
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // A drop in the same cycle as clr restarts the tally at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            ovf      <= 1'b1;
            drop_cnt <= clr ? DROP_W'(1)
                      : (drop_cnt == DROP_MAX) ? DROP_MAX : drop_cnt + DROP_W'(1);
        end else if (clr) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end
    end

    // Head storage drives the outputs directly; once empty, the last popped
    // entry is presented instead so the data never goes unknown.
    assign head = out_valid ? rd_data : hold_q;
    assign {out_sel, out_result, out_c, out_z, out_n} = head;

endmodule

// File: tb/tb_alu_result_collector.sv
// Bench for alu_result_collector: directed scenarios plus random traffic,
// checked every cycle against a queue-based model.
module tb_alu_result_collector;

    localparam int DEPTH = 4;
    localparam int W     = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, in_c;
    logic [1:0]   in_sel;
    logic [W-1:0] in_result;
    logic         out_valid, out_ready;
    logic [1:0]   out_sel;
    logic [W-1:0] out_result;
    logic         out_c, out_z, out_n;
    logic [2:0]   count;
    logic         ovf;
    logic [7:0]   drop_cnt;
    logic         clr;

    always #5 clk = ~clk;

    alu_result_collector #(.DEPTH(DEPTH), .W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
        .in_result(in_result), .in_c(in_c),
        .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel),
        .out_result(out_result), .out_c(out_c), .out_z(out_z), .out_n(out_n),
        .count(count), .ovf(ovf), .drop_cnt(drop_cnt), .clr(clr)
    );

    typedef struct {
        logic [1:0]   sel;
        logic [W-1:0] res;
        logic         c, z, n;
    } ent_t;

    ent_t m_q[$];
    ent_t m_hold;
    bit   m_ovf;
    int   m_drop;
    int   vectors = 0;
    int   miscompares = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_hold = '{sel: 2'd0, res: '0, c: 1'b0, z: 1'b0, n: 1'b0};
        m_ovf  = 1'b0;
        m_drop = 0;
    endfunction

    // Next state from the inputs presented before the coming edge.
    function automatic void model_step();
        bit full = (m_q.size() >= DEPTH);
        if (m_q.size() > 0 && out_ready) m_hold = m_q.pop_front();
        if (in_valid && !full)
            m_q.push_back('{sel: in_sel, res: in_result, c: in_c,
                            z: (in_result == 0), n: in_result[W-1]});
        if (in_valid && full) begin
            m_ovf  = 1'b1;
            m_drop = clr ? 1 : (m_drop < 255 ? m_drop + 1 : 255);
        end else if (clr) begin
            m_ovf  = 1'b0;
            m_drop = 0;
        end
    endfunction

    function automatic void check_model();
        ent_t h;
        h = (m_q.size() > 0) ? m_q[0] : m_hold;
        chk("count",     32'(count),     32'(m_q.size()));
        chk("in_ready",  32'(in_ready),  32'(m_q.size() < DEPTH));
        chk("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        chk("ovf",       32'(ovf),       32'(m_ovf));
        chk("drop_cnt",  32'(drop_cnt),  32'(m_drop));
        chk("out_sel",   32'(out_sel),   32'(h.sel));
        chk("out_result",32'(out_result),32'(h.res));
        chk("out_c",     32'(out_c),     32'(h.c));
        chk("out_z",     32'(out_z),     32'(h.z));
        chk("out_n",     32'(out_n),     32'(h.n));
    endfunction

    task automatic cyc(input bit iv, input logic [1:0] s, input logic [W-1:0] r,
                       input bit c, input bit ordy, input bit cl);
        in_valid = iv; in_sel = s; in_result = r; in_c = c;
        out_ready = ordy; clr = cl;
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 0; in_sel = 0; in_result = 0; in_c = 0; out_ready = 0; clr = 0;
        model_reset();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready",  32'(in_ready),  1);
        chk("rst_count",     32'(count),     0);
        chk("rst_out_result",32'(out_result),0);
        chk("rst_drop_cnt",  32'(drop_cnt),  0);
        rst_n = 1'b1;
        @(negedge clk);
        check_model();

        // single entry
        cyc(1, 2'd0, 16'd5, 0, 0, 0);
        chk("se_valid", 32'(out_valid), 1);
        chk("se_result",32'(out_result),5);
        chk("se_zn",    32'({out_z, out_n}), 0);
        chk("se_count", 32'(count), 1);
        cyc(0, 0, 0, 0, 1, 0);
        chk("se_empty", 32'(out_valid), 0);

        // flags
        cyc(1, 2'd2, 16'h0000, 0, 0, 0);
        cyc(1, 2'd3, 16'h8000, 1, 0, 0);
        chk("fl_zn0", 32'({out_z, out_n}), 32'b10);
        cyc(0, 0, 0, 0, 1, 0);
        chk("fl_cnz1", 32'({out_c, out_z, out_n}), 32'b101);
        cyc(0, 0, 0, 0, 1, 0);

        // fill and overflow
        for (int i = 1; i <= 4; i++) cyc(1, 2'd1, 16'(i), 0, 0, 0);
        chk("fill_in_ready", 32'(in_ready), 0);
        cyc(1, 2'd1, 16'd5, 0, 0, 0);
        chk("ovf_set",  32'(ovf), 1);
        chk("ovf_drop", 32'(drop_cnt), 1);
        for (int i = 1; i <= 4; i++) begin
            chk("drain_order", 32'(out_result), 32'(i));
            cyc(0, 0, 0, 0, 1, 0);
        end

        // full with simultaneous pop and push
        for (int i = 0; i < 4; i++) cyc(1, 2'd0, 16'(16'h10 + i), 0, 0, 0);
        cyc(1, 2'd0, 16'h99, 0, 1, 0);
        chk("fpp_drop",  32'(drop_cnt), 2);
        chk("fpp_count", 32'(count), 3);
        cyc(1, 2'd0, 16'h20, 0, 0, 0);
        cyc(1, 2'd0, 16'h21, 0, 0, 1);
        chk("clr_drop_ovf", 32'({ovf, drop_cnt}), 32'h101);
        cyc(0, 0, 0, 0, 0, 1);
        chk("clr_only", 32'({ovf, drop_cnt}), 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0);

        // streaming wrap-around
        for (int i = 0; i < 20; i++) begin
            cyc(1, 2'(i), 16'(100 + i), i[0], 1, 0);
            chk("stream_head", 32'(out_result), 32'(100 + i));
            if (count > 1) chk("stream_count", 32'(count), 1);
        end
        cyc(0, 0, 0, 0, 1, 0);
        chk("stream_hold", 32'(out_result), 119);

        // drop counter saturation
        for (int i = 0; i < 4; i++) cyc(1, 2'd0, 16'(i), 0, 0, 0);
        for (int i = 0; i < 260; i++) cyc(1, 2'd1, 16'hdead, 0, 0, 0);
        chk("drop_sat", 32'(drop_cnt), 255);
        cyc(0, 0, 0, 0, 1, 0);
        chk("ovf_count3", 32'({ovf, count}), 32'b1011);

        // asynchronous reset mid-stream
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_count", 32'(count), 0);
        chk("arst_ovf",   32'(ovf), 0);
        chk("arst_data",  32'({out_sel, out_result, out_c, out_z, out_n}), 0);
        model_reset();
        in_valid = 0; out_ready = 0; clr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_model();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 3) != 0), 2'($urandom), 16'($urandom_range(0, 7) == 0 ? 0 : $urandom),
                1'($urandom), ($urandom_range(0, 2) != 0), ($urandom_range(0, 29) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: run did not complete");
        $fatal(1);
    end

endmodule
